// File: rtl/hc_pkg.sv
// Shared types for the host-channel buffer array: command encoding,
// control/status records and default sizing.
package hc_pkg;

    localparam int HC_BUFFER_SIZE  = 8;
    localparam int HC_BUFFER_DEPTH = 64;
    localparam int HC_DATA_WIDTH   = 512;
    localparam int HC_SIZE_WIDTH   = $clog2(HC_BUFFER_DEPTH) + 1;

    // Encoding 2'd3 is left undefined and decodes as idle.
    typedef enum logic [1:0] {
        e_BUFFER_IDLE    = 2'd0,
        e_BUFFER_ENQUEUE = 2'd1,
        e_BUFFER_DEQUEUE = 2'd2
    } t_buffer_cmd;

    typedef logic [HC_DATA_WIDTH-1:0] t_buffer_data;
    typedef logic [HC_SIZE_WIDTH-1:0] t_buffer_size;

    typedef struct packed {
        t_buffer_cmd cmd;
    } t_buffer_control;

    typedef struct packed {
        t_buffer_size count;
        logic         empty;
        logic         full;
    } t_buffer_status;

endpackage

// File: rtl/hc_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module hc_sdp_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/hc_buffer_fifo.sv
// Per-buffer FIFO: user control/status channel plus engine push/pop port,
// user side wins arbitration; one push and one pop per cycle.
module hc_buffer_fifo
    import hc_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [1:0]            ctl_cmd,
    input  logic [DATA_WIDTH-1:0] ctl_data,
    output logic [DATA_WIDTH-1:0] usr_data,
    output logic                  usr_valid,
    input  logic                  eng_push,
    input  logic [DATA_WIDTH-1:0] eng_push_data,
    output logic                  eng_push_ready,
    input  logic                  eng_pop,
    output logic                  eng_pop_ready,
    output logic [DATA_WIDTH-1:0] eng_data,
    output logic                  eng_valid,
    output logic [SIZE_WIDTH-1:0] st_count,
    output logic                  st_empty,
    output logic                  st_full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [SIZE_WIDTH-1:0] FULL_CNT = SIZE_WIDTH'(DEPTH);

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [SIZE_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] ram_q, usr_hold, eng_hold, push_data;
    logic is_empty, is_full, usr_enq, usr_deq;
    logic push_req, pop_req, push_acc, pop_acc;

    assign is_empty = (count == '0);
    assign is_full  = (count == FULL_CNT);
    assign usr_enq  = (ctl_cmd == e_BUFFER_ENQUEUE);
    assign usr_deq  = (ctl_cmd == e_BUFFER_DEQUEUE);

    assign eng_push_ready = !is_full  && !usr_enq;
    assign eng_pop_ready  = !is_empty && !usr_deq;

    // Engine requests only count once ready, so they never raise an error flag.
    assign push_req  = usr_enq || (eng_push && eng_push_ready);
    assign pop_req   = usr_deq || (eng_pop  && eng_pop_ready);
    assign push_acc  = reset_n && !flush && push_req && !is_full;
    assign pop_acc   = reset_n && !flush && pop_req  && !is_empty;
    assign push_data = usr_enq ? ctl_data : eng_push_data;

    hc_sdp_ram #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (push_data),
        .re    (pop_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Read data is live from the RAM register in the valid cycle, then held.
    assign usr_data = usr_valid ? ram_q : usr_hold;
    assign eng_data = eng_valid ? ram_q : eng_hold;

    assign st_count = count;
    assign st_empty = is_empty;
    assign st_full  = is_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            usr_valid     <= 1'b0;
            eng_valid     <= 1'b0;
            usr_hold      <= '0;
            eng_hold      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            usr_valid <= pop_acc && usr_deq;
            eng_valid <= pop_acc && !usr_deq;
            if (usr_valid) usr_hold <= ram_q;
            if (eng_valid) eng_hold <= ram_q;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_acc) wr_ptr <= wr_ptr + AW'(1);
                if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
                if (push_acc && !pop_acc)      count <= count + SIZE_WIDTH'(1);
                else if (pop_acc && !push_acc) count <= count - SIZE_WIDTH'(1);
                if (push_req && is_full)  err_overflow  <= 1'b1;
                if (pop_req  && is_empty) err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hc_buffer_fifo.sv
// Self-checking bench for hc_buffer_fifo (DEPTH=4) against a queue-based model.
module tb_hc_buffer_fifo;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int SW    = 3;

    logic          clk = 1'b0;
    logic          reset_n, flush, eng_push, eng_pop;
    logic [1:0]    ctl_cmd;
    logic [DW-1:0] ctl_data, eng_push_data, usr_data, eng_data;
    logic          usr_valid, eng_push_ready, eng_pop_ready, eng_valid;
    logic [SW-1:0] st_count;
    logic          st_empty, st_full, err_overflow, err_underflow;

    always #5 clk = ~clk;

    hc_buffer_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .ctl_cmd(ctl_cmd), .ctl_data(ctl_data),
        .usr_data(usr_data), .usr_valid(usr_valid),
        .eng_push(eng_push), .eng_push_data(eng_push_data), .eng_push_ready(eng_push_ready),
        .eng_pop(eng_pop), .eng_pop_ready(eng_pop_ready),
        .eng_data(eng_data), .eng_valid(eng_valid),
        .st_count(st_count), .st_empty(st_empty), .st_full(st_full),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a plain queue plus the last value handed to each side.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_usr_data, m_eng_data;
    logic          m_usr_valid, m_eng_valid, m_of, m_uf;

    task automatic tick();
        logic [DW-1:0] v;
        int  pre;
        bit  enq, deq, ep, eo;
        m_usr_valid = 1'b0;
        m_eng_valid = 1'b0;
        if (!reset_n) begin
            mq.delete();
            m_of = 1'b0; m_uf = 1'b0; m_usr_data = '0; m_eng_data = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            pre = mq.size();
            enq = (ctl_cmd == 2'd1);
            deq = (ctl_cmd == 2'd2);
            ep  = eng_push && pre < DEPTH && !enq;
            eo  = eng_pop && pre > 0 && !deq;
            if (deq || eo) begin
                if (pre > 0) begin
                    v = mq.pop_front();
                    if (deq) begin m_usr_valid = 1'b1; m_usr_data = v; end
                    else     begin m_eng_valid = 1'b1; m_eng_data = v; end
                end else m_uf = 1'b1;
            end
            if (enq || ep) begin
                if (pre < DEPTH) mq.push_back(enq ? ctl_data : eng_push_data);
                else m_of = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; ctl_cmd = 2'd0; ctl_data = '0;
        eng_push = 0; eng_push_data = '0; eng_pop = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick();
        tick();
        n_cmp++; if (st_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", st_count); end
        n_cmp++; if (st_empty !== 1'b1 || st_full !== 1'b0) begin n_err++; $display("FAIL reset_flags: empty=%b full=%b want 1/0", st_empty, st_full); end
        n_cmp++; if (usr_valid !== 1'b0 || eng_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: usr=%b eng=%b want 0/0", usr_valid, eng_valid); end
        n_cmp++; if (usr_data !== '0 || eng_data !== '0) begin n_err++; $display("FAIL reset_data: usr=%0h eng=%0h want 0/0", usr_data, eng_data); end
        n_cmp++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err: of=%b uf=%b want 0/0", err_overflow, err_underflow); end
        reset_n = 1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            ctl_cmd = 2'd1; ctl_data = DW'(32'hA0 + i);
            tick();
            n_cmp++; if (st_count !== SW'(i + 1)) begin n_err++; $display("FAIL fill_count%0d: got %0d want %0d", i, st_count, i + 1); end
        end
        ctl_cmd = 2'd0; eng_push = 1; eng_push_data = 32'hEE;
        #1;
        n_cmp++; if (st_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", st_full); end
        n_cmp++; if (eng_push_ready !== 1'b0) begin n_err++; $display("FAIL fill_push_ready: got %b want 0", eng_push_ready); end
        tick();
        eng_push = 0;
        n_cmp++; if (st_count !== 3'd4 || err_overflow !== 1'b0) begin n_err++; $display("FAIL fill_unready_push: count=%0d of=%b want 4/0", st_count, err_overflow); end
    endtask

    task automatic test_drain();
        eng_pop = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (eng_pop_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready%0d: got %b want 1", i, eng_pop_ready); end
            tick();
            n_cmp++; if (eng_valid !== 1'b1 || eng_data !== DW'(32'hA0 + i)) begin n_err++; $display("FAIL drain_data%0d: valid=%b data=%0h want 1/%0h", i, eng_valid, eng_data, 32'hA0 + i); end
        end
        eng_pop = 0;
        tick();
        n_cmp++; if (eng_valid !== 1'b0 || st_empty !== 1'b1) begin n_err++; $display("FAIL drain_end: valid=%b empty=%b want 0/1", eng_valid, st_empty); end
        n_cmp++; if (eng_data !== 32'hA3) begin n_err++; $display("FAIL drain_hold: got %0h want a3", eng_data); end
    endtask

    task automatic test_underflow();
        ctl_cmd = 2'd2;
        #1;
        n_cmp++; if (eng_pop_ready !== 1'b0) begin n_err++; $display("FAIL uf_pop_ready: got %b want 0", eng_pop_ready); end
        tick();
        n_cmp++; if (usr_valid !== 1'b0 || err_underflow !== 1'b1 || st_count !== 3'd0) begin n_err++; $display("FAIL uf_flag: valid=%b uf=%b count=%0d want 0/1/0", usr_valid, err_underflow, st_count); end
        ctl_cmd = 2'd1; ctl_data = 32'h55;
        tick();
        ctl_cmd = 2'd2;
        tick();
        ctl_cmd = 2'd0;
        n_cmp++; if (usr_valid !== 1'b1 || usr_data !== 32'h55 || err_underflow !== 1'b1) begin n_err++; $display("FAIL uf_recover: valid=%b data=%0h uf=%b want 1/55/1", usr_valid, usr_data, err_underflow); end
    endtask

    task automatic test_arbitration();
        ctl_cmd = 2'd1; ctl_data = 32'hB0; tick();
        ctl_data = 32'hB1; tick();
        ctl_data = 32'h11; eng_push = 1; eng_push_data = 32'h99;
        #1;
        n_cmp++; if (eng_push_ready !== 1'b0) begin n_err++; $display("FAIL arb_push_ready: got %b want 0", eng_push_ready); end
        tick();
        n_cmp++; if (st_count !== 3'd3) begin n_err++; $display("FAIL arb_count: got %0d want 3", st_count); end
        ctl_cmd = 2'd2; eng_push_data = 32'h77;
        #1;
        n_cmp++; if (eng_push_ready !== 1'b1) begin n_err++; $display("FAIL arb_push_ready2: got %b want 1", eng_push_ready); end
        tick();
        ctl_cmd = 2'd0; eng_push = 0;
        n_cmp++; if (st_count !== 3'd3 || usr_valid !== 1'b1 || usr_data !== 32'hB0) begin n_err++; $display("FAIL arb_pushpop: count=%0d valid=%b data=%0h want 3/1/b0", st_count, usr_valid, usr_data); end
    endtask

    task automatic test_overflow();
        ctl_cmd = 2'd1; ctl_data = 32'hC0; tick();
        n_cmp++; if (st_full !== 1'b1) begin n_err++; $display("FAIL of_full: got %b want 1", st_full); end
        ctl_data = 32'hDD; eng_pop = 1;
        #1;
        n_cmp++; if (eng_pop_ready !== 1'b1) begin n_err++; $display("FAIL of_pop_ready: got %b want 1", eng_pop_ready); end
        tick();
        ctl_cmd = 2'd0; eng_pop = 0;
        n_cmp++; if (st_count !== 3'd3 || err_overflow !== 1'b1) begin n_err++; $display("FAIL of_flag: count=%0d of=%b want 3/1", st_count, err_overflow); end
        n_cmp++; if (eng_valid !== 1'b1 || eng_data !== 32'hB1) begin n_err++; $display("FAIL of_pop: valid=%b data=%0h want 1/b1", eng_valid, eng_data); end
    endtask

    task automatic test_flush();
        ctl_cmd = 2'd2; tick();
        ctl_cmd = 2'd1; ctl_data = 32'hF0; eng_push = 1; flush = 1;
        n_cmp++; if (usr_valid !== 1'b1 || usr_data !== 32'h11) begin n_err++; $display("FAIL flush_prior_pop: valid=%b data=%0h want 1/11", usr_valid, usr_data); end
        tick();
        flush = 0; eng_push = 0; ctl_cmd = 2'd0;
        n_cmp++; if (st_count !== 3'd0 || st_empty !== 1'b1 || usr_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear: count=%0d empty=%b valid=%b want 0/1/0", st_count, st_empty, usr_valid); end
        n_cmp++; if (err_overflow !== 1'b1 || err_underflow !== 1'b1) begin n_err++; $display("FAIL flush_sticky: of=%b uf=%b want 1/1", err_overflow, err_underflow); end
        ctl_cmd = 2'd1; ctl_data = 32'hE0; tick();
        ctl_cmd = 2'd2; tick();
        ctl_cmd = 2'd0;
        n_cmp++; if (usr_valid !== 1'b1 || usr_data !== 32'hE0) begin n_err++; $display("FAIL flush_reuse: valid=%b data=%0h want 1/e0", usr_valid, usr_data); end
    endtask

    task automatic test_random();
        reset_n = 0; idle_inputs(); tick(); reset_n = 1;
        for (int i = 0; i < 400; i++) begin
            ctl_cmd       = 2'($urandom_range(0, 3));
            ctl_data      = $urandom;
            eng_push      = 1'($urandom_range(0, 1));
            eng_push_data = $urandom;
            eng_pop       = 1'($urandom_range(0, 1));
            flush         = ($urandom_range(0, 31) == 0);
            #1;
            n_cmp++; if (eng_push_ready !== (mq.size() < DEPTH && ctl_cmd != 2'd1)) begin n_err++; $display("FAIL rnd_push_ready@%0d: got %b", i, eng_push_ready); end
            n_cmp++; if (eng_pop_ready !== (mq.size() > 0 && ctl_cmd != 2'd2)) begin n_err++; $display("FAIL rnd_pop_ready@%0d: got %b", i, eng_pop_ready); end
            tick();
            n_cmp++; if (st_count !== SW'(mq.size()) || st_empty !== (mq.size() == 0) || st_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rnd_status@%0d: count=%0d empty=%b full=%b want count %0d", i, st_count, st_empty, st_full, mq.size()); end
            n_cmp++; if (usr_valid !== m_usr_valid || usr_data !== m_usr_data) begin n_err++; $display("FAIL rnd_usr@%0d: %b/%0h want %b/%0h", i, usr_valid, usr_data, m_usr_valid, m_usr_data); end
            n_cmp++; if (eng_valid !== m_eng_valid || eng_data !== m_eng_data) begin n_err++; $display("FAIL rnd_eng@%0d: %b/%0h want %b/%0h", i, eng_valid, eng_data, m_eng_valid, m_eng_data); end
            n_cmp++; if (err_overflow !== m_of || err_underflow !== m_uf) begin n_err++; $display("FAIL rnd_err@%0d: of=%b uf=%b want %b/%b", i, err_overflow, err_underflow, m_of, m_uf); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        ctl_cmd = 2'd1; ctl_data = 32'h31; tick();
        ctl_data = 32'h32; eng_pop = 1; tick();
        ctl_cmd = 2'd2; reset_n = 0; tick();
        n_cmp++; if (usr_valid !== 1'b0 || eng_valid !== 1'b0 || usr_data !== '0 || eng_data !== '0) begin n_err++; $display("FAIL rst_mid_out: %b %b %0h %0h want all 0", usr_valid, eng_valid, usr_data, eng_data); end
        n_cmp++; if (st_count !== 3'd0 || st_empty !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_state: count=%0d empty=%b of=%b uf=%b", st_count, st_empty, err_overflow, err_underflow); end
        reset_n = 1; idle_inputs(); tick();
        n_cmp++; if (usr_valid !== 1'b0 || eng_valid !== 1'b0 || st_count !== 3'd0) begin n_err++; $display("FAIL rst_mid_after: usr=%b eng=%b count=%0d want 0/0/0", usr_valid, eng_valid, st_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_arbitration();
        test_overflow();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
